// File: rtl/lsu_subword_ctrl_pkg.sv
// Shared definitions for the sub-word load/store controller: size codes,
// FSM state encoding and the latched request record.
package lsu_pkg;

  localparam int unsigned MEM_BYTES_DEF = 256;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } req_t;

  // Illegal size reports 4 so the range check still sees a sane value.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_subword_ctrl_if.sv
// CPU-side request/response and memory word-port signals of the controller.
interface lsu_subword_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_size;
  logic              cpu_unsigned;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_done;
  logic              cpu_err;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_MemRead;
  logic              mem_MemWrite;
  logic [31:0]       mem_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_done, cpu_err, busy,
    output mem_addr, mem_wdata, mem_MemRead, mem_MemWrite
  );

  modport slave (
    output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_done, cpu_err, busy,
    input  mem_addr, mem_wdata, mem_MemRead, mem_MemWrite
  );
endinterface

// File: rtl/lsu_subword_ctrl_lane.sv
// Big-endian lane extract/extend for loads and lane merge for stores;
// shared by the load and store paths of the controller.
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] mem_word_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte lane k sits at bits [31-8k : 24-8k].
  always_comb begin
    byte_sel = 8'h00;
    case (addr_i)
      2'd0: byte_sel = mem_word_i[31:24];
      2'd1: byte_sel = mem_word_i[23:16];
      2'd2: byte_sel = mem_word_i[15:8];
      default: byte_sel = mem_word_i[7:0];
    endcase
    half_sel = addr_i[1] ? mem_word_i[15:0] : mem_word_i[31:16];
  end

  always_comb begin
    load_data_o = mem_word_i;
    case (size_i)
      SZ_BYTE: load_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: load_data_o = mem_word_i;
    endcase
  end

  always_comb begin
    store_word_o = mem_word_i;
    case (size_i)
      SZ_BYTE: begin
        case (addr_i)
          2'd0: store_word_o[31:24] = store_data_i[7:0];
          2'd1: store_word_o[23:16] = store_data_i[7:0];
          2'd2: store_word_o[15:8]  = store_data_i[7:0];
          default: store_word_o[7:0] = store_data_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_i[1]) store_word_o[15:0]  = store_data_i[15:0];
        else           store_word_o[31:16] = store_data_i[15:0];
      end
      SZ_WORD: store_word_o = store_data_i;
      default: store_word_o = mem_word_i;
    endcase
  end

endmodule

// File: rtl/lsu_subword_ctrl.sv
// Turns CPU byte/half/word loads and stores into whole-word memory accesses,
// with read-modify-write for sub-word stores and up-front error checking.
//
//   state | meaning
//   IDLE  | waiting for cpu_req; request latched and checked here
//   RD    | MemRead strobe; memory word captured at the edge
//   WR    | MemWrite strobe with the merged word
//   DONE  | one-cycle cpu_done (with cpu_err on a rejected request)
module lsu_subword_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                 CLK,
  input  logic                 reset,
  lsu_subword_ctrl_if.master   bus
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  req_t              req_q, req_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [ADDR_W:0]   end_addr;
  logic              acc_err;
  logic [31:0]       lane_word;
  logic [31:0]       load_val;
  logic [31:0]       store_word;

  // One past the last byte touched; one extra bit so the top of the space cannot wrap.
  assign end_addr = {1'b0, bus.cpu_addr} + {{(ADDR_W-2){1'b0}}, size_bytes(bus.cpu_size)};

  assign acc_err = (bus.cpu_size == SZ_ILL)
                || (bus.cpu_size == SZ_HALF && bus.cpu_addr[0])
                || (bus.cpu_size == SZ_WORD && bus.cpu_addr[1:0] != 2'b00)
                || (end_addr > MEM_LIMIT);

  // Loads extract straight from the live read data; stores merge into the buffered word.
  assign lane_word = (state_q == ST_RD) ? bus.mem_rdata : word_q;

  lsu_lane_unit u_lane (
    .addr_i       (addr_q[1:0]),
    .size_i       (req_q.size),
    .unsigned_i   (req_q.uns),
    .mem_word_i   (lane_word),
    .store_data_i (req_q.wdata),
    .load_data_o  (load_val),
    .store_word_o (store_word)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    req_d   = req_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          addr_d = bus.cpu_addr;
          req_d  = '{we: bus.cpu_we, size: bus.cpu_size,
                     uns: bus.cpu_unsigned, wdata: bus.cpu_wdata};
          err_d  = acc_err;
          if (acc_err)                                  state_d = ST_DONE;
          else if (bus.cpu_we && bus.cpu_size == SZ_WORD) state_d = ST_WR;
          else                                          state_d = ST_RD;
        end
      end
      ST_RD: begin
        word_d = bus.mem_rdata;
        if (req_q.we) begin
          state_d = ST_WR;
        end else begin
          rdata_d = load_val;
          state_d = ST_DONE;
        end
      end
      ST_WR:   state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      req_q   <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.cpu_done     = (state_q == ST_DONE);
  assign bus.cpu_err      = (state_q == ST_DONE) && err_q;
  assign bus.cpu_rdata    = rdata_q;
  assign bus.mem_MemRead  = (state_q == ST_RD);
  assign bus.mem_MemWrite = (state_q == ST_WR);
  assign bus.mem_addr     = (state_q == ST_RD || state_q == ST_WR)
                          ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.mem_wdata    = (state_q == ST_WR) ? store_word : 32'h0;

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Bench for lsu_subword_ctrl: byte-array memory behind the word port, a
// byte-level model that predicts every output cycle, plus literal checks.
module tb_lsu_subword_ctrl;
  import lsu_pkg::*;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  lsu_subword_ctrl_if #(.ADDR_W(32)) bus();

  lsu_subword_ctrl #(.MEM_BYTES(256), .ADDR_W(32)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  // Physical memory seen by the DUT; returns junk whenever it is not being read.
  logic [7:0] pmem [0:255];
  logic [7:0] ra;
  assign ra = bus.mem_addr[7:0];
  assign bus.mem_rdata = bus.mem_MemRead
                       ? {pmem[ra], pmem[ra+8'd1], pmem[ra+8'd2], pmem[ra+8'd3]}
                       : 32'h5A5AA5A5;

  always @(posedge CLK) begin
    if (bus.mem_MemWrite) begin
      pmem[ra]       = bus.mem_wdata[31:24];
      pmem[ra+8'd1]  = bus.mem_wdata[23:16];
      pmem[ra+8'd2]  = bus.mem_wdata[15:8];
      pmem[ra+8'd3]  = bus.mem_wdata[7:0];
    end
  end

  function automatic logic [31:0] pword(input int a);
    return {pmem[a], pmem[a+1], pmem[a+2], pmem[a+3]};
  endfunction

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic        rd;
    logic        wr;
    logic        chk_addr;
    logic        chk_wdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  bit          chk_en = 1'b0;
  exp_t        exp_q[$];
  logic [31:0] model_rdata;
  logic [7:0]  mm [0:255];

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    e.chk_addr = 1'b1;
    e.rdata = model_rdata;
    return e;
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      exp_t e;
      logic ok;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = idle_exp();
      ok = (bus.busy === e.busy) && (bus.cpu_done === e.done) && (bus.cpu_err === e.err)
        && (bus.mem_MemRead === e.rd) && (bus.mem_MemWrite === e.wr)
        && (bus.cpu_rdata === e.rdata)
        && (!e.chk_addr || bus.mem_addr === e.addr)
        && (!e.chk_wdata || bus.mem_wdata === e.wdata);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL cycle @%0t got busy=%b done=%b err=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h want busy=%b done=%b err=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h",
                 $time, bus.busy, bus.cpu_done, bus.cpu_err, bus.mem_MemRead, bus.mem_MemWrite,
                 bus.mem_addr, bus.mem_wdata, bus.cpu_rdata,
                 e.busy, e.done, e.err, e.rd, e.wr, e.addr, e.wdata, e.rdata);
      end
    end
  end

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  // Predicts the whole transaction from byte-level memory semantics, then drives it.
  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input bit rst_in_rd);
    int          nb;
    int          n;
    bit          er;
    logic [31:0] al, ld, nw;
    logic [7:0]  b;
    exp_t        e;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
      || ({1'b0, a} + 33'(nb) > 33'd256);
    al = {a[31:2], 2'b00};
    ld = '0;
    nw = '0;
    if (!er) begin
      for (int i = 0; i < nb; i++) ld = (ld << 8) | 32'(mm[8'(a + 32'(i))]);
      if (!uns && nb < 4 && ld[8*nb-1]) ld = ld | (32'hFFFFFFFF << (8*nb));
      for (int j = 0; j < 4; j++) begin
        b = mm[8'(al + 32'(j))];
        if (al + 32'(j) >= a && al + 32'(j) < a + 32'(nb))
          b = wd[8*(nb-1-int'(al + 32'(j) - a)) +: 8];
        nw = (nw << 8) | 32'(b);
      end
    end

    @(negedge CLK);
    #1;
    bus.cpu_we = we; bus.cpu_size = sz; bus.cpu_unsigned = uns;
    bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_req = 1'b1;

    n = 0;
    e = '0;
    e.busy = 1'b1;
    e.chk_addr = 1'b1;
    e.rdata = model_rdata;
    if (er) begin
      e.done = 1'b1; e.err = 1'b1; e.chk_addr = 1'b0;
      exp_q.push_back(e); n++;
    end else begin
      if (!we || nb < 4) begin
        e.rd = 1'b1; e.addr = al;
        exp_q.push_back(e); n++;
        e.rd = 1'b0;
      end
      if (!rst_in_rd) begin
        if (we) begin
          e.wr = 1'b1; e.addr = al; e.wdata = nw; e.chk_wdata = 1'b1;
          exp_q.push_back(e); n++;
          e.wr = 1'b0; e.chk_wdata = 1'b0;
        end else begin
          model_rdata = ld;
        end
        e.addr = '0; e.chk_addr = 1'b0; e.done = 1'b1; e.rdata = model_rdata;
        exp_q.push_back(e); n++;
      end
    end

    if (rst_in_rd) begin
      @(negedge CLK);
      #1;
      reset = 1'b1; bus.cpu_req = 1'b0; model_rdata = '0;
      @(negedge CLK);
      #1;
      reset = 1'b0;
    end else begin
      repeat (n) @(negedge CLK);
      #1;
      bus.cpu_req = 1'b0;
      if (we && !er)
        for (int i = 0; i < nb; i++) mm[8'(a + 32'(i))] = wd[8*(nb-1-i) +: 8];
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_size = 2'd0; bus.cpu_unsigned = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    model_rdata = '0;
    for (int i = 0; i < 256; i++) begin pmem[i] = 8'h00; mm[i] = 8'h00; end
    pmem[32'h20] = 8'h88; pmem[32'h21] = 8'h99; pmem[32'h22] = 8'hAA; pmem[32'h23] = 8'hBB;
    mm[32'h20]   = 8'h88; mm[32'h21]   = 8'h99; mm[32'h22]   = 8'hAA; mm[32'h23]   = 8'hBB;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check32("rst_flags", {27'b0, bus.busy, bus.cpu_done, bus.cpu_err, bus.mem_MemRead, bus.mem_MemWrite}, 32'h0);
    check32("rst_rdata", bus.cpu_rdata, 32'h0);
    check32("rst_addr",  bus.mem_addr,  32'h0);
    check32("rst_wdata", bus.mem_wdata, 32'h0);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;

    txn(1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, 1'b0); check32("lb_20",  bus.cpu_rdata, 32'hFFFFFF88);
    txn(1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0, 1'b0); check32("lbu_20", bus.cpu_rdata, 32'h00000088);
    txn(1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 1'b0); check32("lh_22",  bus.cpu_rdata, 32'hFFFFAABB);
    txn(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 1'b0); check32("lhu_22", bus.cpu_rdata, 32'h0000AABB);
    txn(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0); check32("lw_20",  bus.cpu_rdata, 32'h8899AABB);

    txn(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h1234565A, 1'b0);
    check32("sb_keeps_rdata", bus.cpu_rdata, 32'h8899AABB);
    check32("sb_mem_20", pword(32'h20), 32'h885AAABB);
    txn(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0); check32("lw_20_after_sb", bus.cpu_rdata, 32'h885AAABB);

    txn(1'b1, SZ_WORD, 1'b0, 32'h30, 32'hDEADBEEF, 1'b0);
    check32("sw_mem_30", pword(32'h30), 32'hDEADBEEF);
    txn(1'b0, SZ_BYTE, 1'b0, 32'h33, 32'h0, 1'b0); check32("lb_33", bus.cpu_rdata, 32'hFFFFFFEF);

    txn(1'b1, SZ_HALF, 1'b0, 32'h23, 32'h0000CAFE, 1'b0);
    check32("sh_23_err_rdata", bus.cpu_rdata, 32'hFFFFFFEF);
    check32("sh_23_err_mem", pword(32'h20), 32'h885AAABB);
    txn(1'b0, SZ_WORD, 1'b0, 32'h22, 32'h0, 1'b0); check32("lw_22_err_rdata", bus.cpu_rdata, 32'hFFFFFFEF);
    txn(1'b0, SZ_ILL,  1'b0, 32'hFC, 32'h0, 1'b0); check32("sz3_fc_err_rdata", bus.cpu_rdata, 32'hFFFFFFEF);
    txn(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 1'b0); check32("lw_100_err_rdata", bus.cpu_rdata, 32'hFFFFFFEF);

    txn(1'b1, SZ_HALF, 1'b0, 32'hFE, 32'h1234BEEF, 1'b0);
    check32("sh_fe_mem", pword(32'hFC), 32'h0000BEEF);
    txn(1'b0, SZ_HALF, 1'b0, 32'hFE, 32'h0, 1'b0); check32("lh_fe",  bus.cpu_rdata, 32'hFFFFBEEF);
    txn(1'b0, SZ_HALF, 1'b1, 32'hFE, 32'h0, 1'b0); check32("lhu_fe", bus.cpu_rdata, 32'h0000BEEF);
    txn(1'b0, SZ_BYTE, 1'b1, 32'hFF, 32'h0, 1'b0); check32("lbu_ff", bus.cpu_rdata, 32'h000000EF);

    txn(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h00000077, 1'b1);
    check32("rst_rd_rdata", bus.cpu_rdata, 32'h0);
    check32("rst_rd_busy", {31'b0, bus.busy}, 32'h0);
    check32("rst_rd_mem_20", pword(32'h20), 32'h885AAABB);
    txn(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0); check32("lw_20_after_rst", bus.cpu_rdata, 32'h885AAABB);

    repeat (3) @(negedge CLK);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
